// File: rtl/beep_arbiter.sv
// beep_arbiter: arbitrates stopwatch tick, hourly chime and alarm onto one 500 Hz buzzer.
// Define BEEP_SNOOZE_EN to make ack in ALARM snooze instead of stopping the alarm.
module beep_arbiter #(
  parameter int CHIME_SEC  = 5,
  parameter int ALARM_SEC  = 30,
  parameter int SNOOZE_SEC = 60,
  parameter int TICK_MS    = 50
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       req_chime,
  input  logic       req_alarm,
  input  logic       req_tick,
  input  logic       ack,
  input  logic       debug_force,
  output logic       beep,
  output logic       busy,
  output logic [1:0] active_src
);
  typedef enum logic [2:0] {
    IDLE, TICK, CHIME, ALARM
`ifdef BEEP_SNOOZE_EN
    , SNOOZE
`endif
  } state_e;
  localparam logic [9:0] TICK_N     = 10'(TICK_MS);
  localparam logic [7:0] CHIME_END  = 8'(CHIME_SEC - 1);
  localparam logic [7:0] ALARM_END  = 8'(ALARM_SEC - 1);
  localparam logic [7:0] SNOOZE_END = 8'(SNOOZE_SEC - 1);
  state_e state_q, state_d;
  logic [9:0] ms_q, ms_d;
  logic [7:0] sec_q, sec_d, sec_lim;
  logic [1:0] src_q;
  logic tone_q, pend_q, pend_d, alarm_q, beep_q, busy_q;
  logic restart, gate, enter, ms_end, sec_done, alarm_rise;

  assign alarm_rise = req_alarm & ~alarm_q;
  assign ms_end     = ms_q == 10'd999;
  assign sec_lim    = state_q == CHIME ? CHIME_END : state_q == ALARM ? ALARM_END : SNOOZE_END;
  assign sec_done   = ms_end && sec_q == sec_lim;
  // Any state change or chime restart counts as an entry and zeroes both counters.
  assign enter      = restart || state_d != state_q;
  assign ms_d       = enter || ms_end ? '0 : ms_q + 10'd1;
  assign sec_d      = enter ? '0 : sec_q + {7'd0, ms_end};
  assign beep       = beep_q;
  assign busy       = busy_q;
  assign active_src = src_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    restart = 1'b0;
    gate    = 1'b0;
    case (state_q)
      IDLE:
        if (alarm_rise) begin
          state_d = ALARM;
          pend_d  = pend_q | req_chime;
        end else if (req_chime || pend_q) begin
          state_d = CHIME;
          pend_d  = 1'b0;
        end else if (req_tick) state_d = TICK;
      TICK: begin
        gate = ms_q < TICK_N;
        if (alarm_rise) begin
          state_d = ALARM;
          pend_d  = pend_q | req_chime;
        end else if (req_chime) state_d = CHIME;
        else if (ms_q == TICK_N - 10'd1) state_d = IDLE;
      end
      CHIME: begin
        gate = ms_q < 10'd100 || (ms_q >= 10'd200 && ms_q < 10'd300) || (ms_q >= 10'd400 && ms_q < 10'd500);
        if (alarm_rise) begin
          state_d = ALARM;
          pend_d  = 1'b1;
        end else if (req_chime) restart = 1'b1;
        else if (sec_done) state_d = IDLE;
      end
      ALARM: begin
        gate   = ms_q < 10'd500;
        pend_d = pend_q | req_chime;
        if (!req_alarm || sec_done) state_d = IDLE;
        else if (ack)
`ifdef BEEP_SNOOZE_EN
          state_d = SNOOZE;
`else
          state_d = IDLE;
`endif
      end
`ifdef BEEP_SNOOZE_EN
      SNOOZE: begin
        pend_d = pend_q | req_chime;
        if (!req_alarm) state_d = IDLE;
        else if (sec_done) state_d = ALARM;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) begin
      state_q <= IDLE;
      ms_q    <= '0;
      sec_q   <= '0;
      tone_q  <= 1'b0;
      pend_q  <= 1'b0;
      alarm_q <= 1'b0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      src_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
      tone_q  <= ~tone_q;
      pend_q  <= pend_d;
      alarm_q <= req_alarm;
      beep_q  <= tone_q & (gate | debug_force);
      busy_q  <= state_d != IDLE;
      src_q   <= state_d == ALARM ? 2'd3 : state_d == CHIME ? 2'd2 : state_d == TICK ? 2'd1 : 2'd0;
    end
endmodule

// File: tb/tb_beep_arbiter.sv
// tb_beep_arbiter: random and directed stimulus against a time-since-entry reference model.
module tb_beep_arbiter;
  localparam int CH = 2, AL = 4, SN = 3, TK = 50;
  localparam int S_IDLE = 0, S_TICK = 1, S_CHIME = 2, S_ALARM = 3, S_SNOOZE = 4;
`ifdef BEEP_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif
  logic clk_1khz = 1'b0, switch_clr = 1'b0;
  logic req_chime = 1'b0, req_alarm = 1'b0, req_tick = 1'b0, ack = 1'b0, debug_force = 1'b0;
  logic beep, busy;
  logic [1:0] active_src;
  int n_tests = 0, n_fail = 0;
  int m_st, m_t;
  bit m_pend, m_prev, m_tone, m_beep;

  beep_arbiter #(.CHIME_SEC(CH), .ALARM_SEC(AL), .SNOOZE_SEC(SN), .TICK_MS(TK)) dut (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .req_chime(req_chime), .req_alarm(req_alarm),
    .req_tick(req_tick), .ack(ack), .debug_force(debug_force), .beep(beep), .busy(busy),
    .active_src(active_src));

  always #5 clk_1khz = ~clk_1khz;

  function automatic bit gate_of(int st, int t);
    int ms = t % 1000;
    if (st == S_TICK) return t < TK;
    if (st == S_CHIME) return (ms / 100) inside {0, 2, 4};
    if (st == S_ALARM) return ms < 500;
    return 1'b0;
  endfunction

  function automatic logic [3:0] expected();
    logic [1:0] src = m_st == S_SNOOZE ? 2'd0 : 2'(m_st);
    return {m_beep, m_st != S_IDLE, src};
  endfunction

  always @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) begin
      m_st <= S_IDLE; m_t <= 0; m_pend <= 0; m_prev <= 0; m_tone <= 0; m_beep <= 0;
    end else begin : model
      int nx;
      bit re, p, rise;
      rise = req_alarm && !m_prev;
      nx = m_st; re = 0; p = m_pend;
      case (m_st)
        S_IDLE:
          if (rise) begin nx = S_ALARM; p = p | req_chime; end
          else if (req_chime || p) begin nx = S_CHIME; p = 0; end
          else if (req_tick) nx = S_TICK;
        S_TICK:
          if (rise) begin nx = S_ALARM; p = p | req_chime; end
          else if (req_chime) nx = S_CHIME;
          else if (m_t == TK - 1) nx = S_IDLE;
        S_CHIME:
          if (rise) begin nx = S_ALARM; p = 1; end
          else if (req_chime) re = 1;
          else if (m_t == CH * 1000 - 1) nx = S_IDLE;
        S_ALARM: begin
          p = p | req_chime;
          if (!req_alarm || m_t == AL * 1000 - 1) nx = S_IDLE;
          else if (ack) nx = SNOOZE_ON ? S_SNOOZE : S_IDLE;
        end
        default: begin
          p = p | req_chime;
          if (!req_alarm) nx = S_IDLE;
          else if (m_t == SN * 1000 - 1) nx = S_ALARM;
        end
      endcase
      m_beep <= m_tone & (gate_of(m_st, m_t) | debug_force);
      m_tone <= !m_tone;
      m_prev <= req_alarm;
      m_pend <= p;
      m_st   <= nx;
      m_t    <= (nx != m_st || re) ? 0 : m_t + 1;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick1();
    @(posedge clk_1khz);
    @(negedge clk_1khz);
    check("out", {28'd0, beep, busy, active_src}, {28'd0, expected()});
    req_chime = 0; req_tick = 0; ack = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  initial begin
    @(negedge clk_1khz);
    @(negedge clk_1khz);
    check("rst", {29'd0, beep, busy, active_src}, 0);
    switch_clr = 1;
    step(3);
    req_tick = 1; tick1();
    check("tick_src", active_src, 1);
    step(49);
    check("tick_last", active_src, 1);
    tick1();
    check("tick_end", busy, 0);
    req_chime = 1; tick1();
    check("chime_src", active_src, 2);
    step(10);
    req_tick = 1; tick1();
    check("tick_drop", active_src, 2);
    step(1188);
    req_alarm = 1; tick1();
    check("alarm_pre", active_src, 3);
    step(1799);
    req_alarm = 0; tick1();
    check("alarm_fall", busy, 0);
    tick1();
    check("pend_chime", active_src, 2);
    step(1999);
    check("chime_last", active_src, 2);
    tick1();
    check("chime_done", busy, 0);
    req_alarm = 1; tick1();
    check("alarm_src", active_src, 3);
    step(3999);
    check("alarm_last", active_src, 3);
    tick1();
    check("alarm_to", {30'd0, active_src}, 0);
    check("alarm_to_busy", busy, 0);
    req_alarm = 0; step(2);
    req_alarm = 1; tick1();
    step(1999);
    ack = 1; tick1();
    check("ack_busy", busy, SNOOZE_ON);
    check("ack_src", active_src, 0);
    step(2999);
    tick1();
    check("re_alarm", active_src, SNOOZE_ON ? 2'd3 : 2'd0);
    req_alarm = 0; tick1();
    check("alarm_off", busy, 0);
    req_chime = 1; tick1();
    step(300);
    req_alarm = 1; tick1();
    step(50);
    #2 switch_clr = 0;
    #1 check("rst_async", {29'd0, beep, busy, active_src}, 0);
    @(negedge clk_1khz);
    switch_clr = 1;
    tick1();
    check("rel_edge", active_src, 3);
    req_alarm = 0; tick1();
    step(5);
    check("no_chime", busy, 0);
    debug_force = 1; step(6);
    check("dbg_busy", busy, 0);
    check("dbg_beep", beep, expected() >> 3);
    debug_force = 0; step(2);
    for (int i = 0; i < 20000; i++) begin
      req_chime = ($urandom % 300) == 0;
      req_tick  = ($urandom % 80) == 0;
      ack       = ($urandom % 400) == 0;
      if (($urandom % 1200) == 0) req_alarm = !req_alarm;
      if (($urandom % 1500) == 0) debug_force = !debug_force;
      if (($urandom % 4000) == 0) begin
        switch_clr = 0; tick1(); switch_clr = 1;
      end else tick1();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/beep_arbiter.md
BEEP_ARBITER -- requirements
Module: beep_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CHIME_SEC, 5, hourly chime duration in seconds.
- ALARM_SEC, 30, alarm auto-timeout in seconds.
- SNOOZE_SEC, 60, snooze interval in seconds.
- TICK_MS, 50, stopwatch tick duration in ms.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_1khz, input, 1, sole clock; the block samples all inputs on its rising edge.
- switch_clr, input, 1, reset, asynchronous, active-low.
- req_chime, input, 1, one-cycle pulse requesting an hourly chime.
- req_alarm, input, 1, level; a rising edge requests the alarm.
- req_tick, input, 1, one-cycle pulse requesting a stopwatch tick.
- ack, input, 1, one-cycle pulse from a debounced button that stops the alarm.
- debug_force, input, 1, level that forces a continuous tone.
- beep, output, 1, registered buzzer drive.
- busy, output, 1, registered; 1 whenever state is not IDLE.
- active_src, output, 2, registered source code: 0 none or snooze, 1 tick, 2 chime, 3 alarm.

Function
REQ-003 States SHALL be IDLE, TICK, CHIME, ALARM and SNOOZE.
REQ-004 Counters:
- ms counter wraps 0..999.
- sec counter is 8 bits.
- Both counters clear on every state entry, including re-entry.
REQ-005 Tone: tone toggles every cycle (500 Hz), and beep SHALL equal registered (gate AND tone), or registered tone when debug_force=1.
REQ-006 Gate per state:
- TICK: ms < TICK_MS.
- CHIME: ms in [0,100), [200,300) or [400,500).
- ALARM: ms < 500.
- IDLE and SNOOZE: 0.
REQ-007 Priority of simultaneous requests in one cycle SHALL be alarm > chime > tick; the losing chime sets pending_chime and the losing tick is dropped.
REQ-008 IDLE exits:
- On an alarm edge it SHALL go to ALARM.
- Otherwise, on req_chime or pending_chime, it SHALL go to CHIME and clear pending_chime.
- Otherwise, on req_tick, it SHALL go to TICK.
REQ-009 TICK SHALL return to IDLE when ms reaches TICK_MS-1, and an alarm edge or req_chime SHALL preempt it immediately.
REQ-010 CHIME:
- It SHALL return to IDLE after CHIME_SEC full seconds.
- An alarm edge preempts it and sets pending_chime.
- A req_chime restarts the chime.
- A req_tick is dropped.
REQ-011 ALARM:
- It SHALL go to IDLE on ALARM_SEC timeout.
- It SHALL go to IDLE when req_alarm falls.
- ack is handled per REQ-017.
- req_chime sets pending_chime; req_tick is dropped.
REQ-012 pending_chime is one deep: a second chime while one is pending SHALL be lost.
REQ-013 Latency: a request sampled at edge N SHALL give state entry at edge N+1 and first beep=1 no later than edge N+3.
REQ-014 debug_force SHALL NOT alter state, counters or busy/active_src.

Reset
REQ-015 While switch_clr=0, the block SHALL asynchronously hold:
- state IDLE;
- counters, tone and pending_chime at 0;
- the alarm edge detector at 0;
- beep=0, busy=0, active_src=0.
REQ-016 Reset mid-operation SHALL abort any sequence and lose any pending chime; a req_alarm that is high at release SHALL be seen as an edge on the first sampled cycle.

Configuration
REQ-017 Macro BEEP_SNOOZE_EN controls ack handling in ALARM.
- Defined: ack in ALARM SHALL go to SNOOZE. After SNOOZE_SEC seconds SNOOZE re-enters ALARM with counters cleared. req_alarm low in SNOOZE goes to IDLE, and pending_chime is served from IDLE. Snoozes are unlimited.
- Undefined: the SNOOZE state does not exist and ack in ALARM SHALL go to IDLE.
- ack outside ALARM SHALL be ignored in both builds.

Verification
REQ-018 req_chime pulse from IDLE -> active_src=2; 3 bursts of 100 ms per second for 5000 cycles; then busy=0.
REQ-019 req_tick at t=0 -> beep toggles for 50 cycles; IDLE at t≈51; a req_tick during an active CHIME produces no change.
REQ-020 Chime running 1200 ms, then req_alarm rises -> ALARM within 1 cycle with pending_chime=1; req_alarm falls at 3000 ms -> IDLE, then CHIME for 5 s.
REQ-021 Alarm with no ack, req_alarm held high -> ALARM exits to IDLE after exactly 30000 cycles; active_src=0.
REQ-022 BEEP_SNOOZE_EN defined, ack at 2 s into ALARM -> SNOOZE, beep=0 for 60000 cycles, then ALARM again. Undefined build, same stimulus -> IDLE.
REQ-023 switch_clr low mid-CHIME with pending_chime set -> all outputs 0 immediately; after release no chime plays; debug_force=1 in IDLE -> beep toggles each cycle while busy=0.
